boa_cache_line_ctl: RTL

BOA_CACHE_LINE_CTL -- requirements
Module: boa_cache_line_ctl

---
 rtl/boa_cache_line_ctl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/boa_cache_line_ctl.sv
// Cache line controller: optional writeback of one line from the data RAM to
// external memory, then an optional fill of one line from external memory.
//   IDLE  | waiting for a command, cmd_ready high
//   WB_RD | data RAM read of word idx for writeback
//   WB_XM | external write of the buffered word, waits for xm_ready
//   FILL  | external read of word idx, written straight into the data RAM
//   DONE  | one-cycle completion pulse
module boa_cache_line_ctl #(
  parameter int alen      = 24,
  parameter int line_size = 16,
  localparam int iw       = $clog2(line_size),
  localparam int lgrain   = iw + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_evict,
  input  logic                 cmd_fill,
  input  logic [alen-1:lgrain] cmd_evict_addr,
  input  logic [alen-1:lgrain] cmd_fill_addr,
  output logic                 busy,
  output logic                 done,
  output logic [iw-1:0]        dr_addr,
  output logic                 dr_we,
  output logic [31:0]          dr_wdata,
  input  logic [31:0]          dr_rdata,
  output logic                 xm_re,
  output logic [3:0]           xm_we,
  output logic [alen-1:2]      xm_addr,
  output logic [31:0]          xm_wdata,
  input  logic [31:0]          xm_rdata,
  input  logic                 xm_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB_RD = 3'd1,
    WB_XM = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [iw-1:0] idx_last = iw'(line_size - 1);
  localparam logic [iw-1:0] idx_one  = iw'(1);

  state_t                 state_q, state_d;
  logic [iw-1:0]          idx_q, idx_d;
  logic [31:0]            wbuf_q, wbuf_d;
  logic [alen-1:lgrain]   evict_addr_q, evict_addr_d;
  logic [alen-1:lgrain]   fill_addr_q, fill_addr_d;
  logic                   evict_q, evict_d;
  logic                   fill_q, fill_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wbuf_d       = wbuf_q;
    evict_addr_d = evict_addr_q;
    fill_addr_d  = fill_addr_q;
    evict_d      = evict_q;
    fill_d       = fill_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          evict_addr_d = cmd_evict_addr;
          fill_addr_d  = cmd_fill_addr;
          evict_d      = cmd_evict;
          fill_d       = cmd_fill;
          idx_d        = '0;
          if (cmd_evict)     state_d = WB_RD;
          else if (cmd_fill) state_d = FILL;
          else               state_d = DONE;
        end
      end
      WB_RD: begin
        // RAM word is captured here so xm_wdata cannot move during a stall
        wbuf_d  = dr_rdata;
        state_d = WB_XM;
      end
      WB_XM: begin
        if (xm_ready) begin
          if (idx_q == idx_last) begin
            idx_d   = '0;
            state_d = fill_q ? FILL : DONE;
          end else begin
            idx_d   = idx_q + idx_one;
            state_d = WB_RD;
          end
        end
      end
      FILL: begin
        if (xm_ready) begin
          if (idx_q == idx_last) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + idx_one;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wbuf_q       <= '0;
      evict_addr_q <= '0;
      fill_addr_q  <= '0;
      evict_q      <= 1'b0;
      fill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wbuf_q       <= wbuf_d;
      evict_addr_q <= evict_addr_d;
      fill_addr_q  <= fill_addr_d;
      evict_q      <= evict_d;
      fill_q       <= fill_d;
    end
  end

  // Strobes depend on the state flops (and xm_ready for dr_we) only.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign xm_re     = (state_q == FILL);
  assign xm_we     = (state_q == WB_XM) ? 4'hF : 4'h0;
  assign dr_we     = (state_q == FILL) && xm_ready;
  assign dr_addr   = idx_q;
  assign dr_wdata  = xm_rdata;
  assign xm_wdata  = wbuf_q;
  assign xm_addr   = (state_q == FILL) ? {fill_addr_q, idx_q} : {evict_addr_q, idx_q};

endmodule
